// File: rtl/bcd7seg_scan_driver.sv
//==============================================================================
// Module  : bcd7seg_scan_driver
// Purpose : Multiplexed N-digit BCD to 7-segment scan driver with guard gaps
//           and frame-synchronous commit of new values.
// Options : LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd7seg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int COMMON_CATHODE = 1,
  parameter int DIGIT_ACT_LOW  = 0,
  parameter int SCAN_DIV       = 1000,
  parameter int GUARD          = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  load_ack
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0]          c_SEG_OFF = (COMMON_CATHODE != 0) ? 7'h00 : 7'h7F;
  localparam logic [N_DIGITS-1:0] c_DIG_OFF = (DIGIT_ACT_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]      r_divCnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [4*N_DIGITS-1:0] r_display;
  logic                  r_pending;

  logic                  w_slotEnd;
  logic                  w_frameEnd;
  logic                  w_guardDone;
  logic [3:0]            w_digits [N_DIGITS];
  logic [N_DIGITS-1:0]   w_blank;
  logic [N_DIGITS-1:0]   w_oneHot;
  logic [N_DIGITS-1:0]   w_sel;
  logic [6:0]            w_lit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  assign w_slotEnd  = (r_divCnt == CNT_W'(SCAN_DIV - 1));
  assign w_frameEnd = w_slotEnd && (r_idx == IDX_W'(N_DIGITS - 1));

  generate
    if (GUARD == 0) begin : g_noGuard
      assign w_guardDone = 1'b1;
    end else begin : g_guard
      assign w_guardDone = (r_divCnt >= CNT_W'(GUARD));
    end
  endgenerate

  generate
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digits
      assign w_digits[k] = r_display[4*k +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more-significant digit are zero.
  always_comb begin
    logic zeroAbove;
    w_blank   = '0;
    zeroAbove = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      zeroAbove  = zeroAbove && (w_digits[k] == 4'd0);
      w_blank[k] = zeroAbove;
    end
  end
`else
  assign w_blank = '0;
`endif

  always_comb begin
    w_oneHot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_oneHot[k] = (r_idx == IDX_W'(k));
    end
  end

  assign w_sel = w_guardDone ? w_oneHot : '0;
  assign w_lit = w_blank[r_idx] ? 7'h00 : decode(w_digits[r_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_divCnt <= '0;
      r_idx    <= '0;
    end else begin
      r_divCnt <= w_slotEnd ? '0 : r_divCnt + 1'b1;
      if (w_slotEnd) begin
        r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // A load on the boundary edge still commits the older shadow; the new
  // value stays pending for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_display <= '0;
      r_pending <= 1'b0;
      load_ack  <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (w_frameEnd && r_pending) begin
        r_display <= r_shadow;
        r_pending <= 1'b0;
        load_ack  <= 1'b1;
      end
      if (load) begin
        r_shadow  <= bcd_in;
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg      <= c_SEG_OFF;
      digit_en <= c_DIG_OFF;
    end else begin
      seg      <= (COMMON_CATHODE != 0) ? w_lit : ~w_lit;
      digit_en <= (DIGIT_ACT_LOW != 0) ? ~w_sel : w_sel;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd7seg_scan_driver.sv
//==============================================================================
// Module  : tb_bcd7seg_scan_driver
// Purpose : Self-checking bench for bcd7seg_scan_driver (4 digits, SCAN_DIV=8).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcd7seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GD = 2;
  localparam int FR = ND * SD;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        load_ack;

  always #5 clk = ~clk;

  bcd7seg_scan_driver #(
    .N_DIGITS(ND), .COMMON_CATHODE(1), .DIGIT_ACT_LOW(0), .SCAN_DIV(SD), .GUARD(GD)
  ) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg), .digit_en(digit_en), .load_ack(load_ack)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] den;
    logic       ack;
  } exp_t;

  typedef struct packed {
    logic [15:0]     val;
    logic [3:0][6:0] exp;   // {d3,d2,d1,d0}
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl [7];
  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  int          lastIdx = -1;
  int          lastDiv = -1;
  int          ackSeen = 0;
  logic [15:0] mShadow = 16'h0;
  logic [15:0] mDisplay = 16'h0;
  bit          mPending = 1'b0;

  function automatic logic [6:0] expSeg(input logic [15:0] disp, input int k);
    logic [3:0] d;
    d = disp[4*k +: 4];
    case (d)
      4'd0: expSeg = 7'h3F;  4'd1: expSeg = 7'h06;
      4'd2: expSeg = 7'h5B;  4'd3: expSeg = 7'h4F;
      4'd4: expSeg = 7'h66;  4'd5: expSeg = 7'h6D;
      4'd6: expSeg = 7'h7D;  4'd7: expSeg = 7'h07;
      4'd8: expSeg = 7'h7F;  4'd9: expSeg = 7'h6F;
      default: expSeg = 7'h00;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (disp >> (4*k)) == 16'h0) expSeg = 7'h00;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, t);
    end
  endtask

  // One clock: predict the registered outputs, queue them, clock, compare.
  task automatic step(input bit r, input bit l, input logic [15:0] b);
    exp_t e;
    exp_t g;
    int   div;
    int   idx;
    bit   bnd;
    rst = r; load = l; bcd_in = b;
    if (r) begin
      e.seg = 7'h00; e.den = 4'h0; e.ack = 1'b0;
      t = 0; mShadow = 16'h0; mDisplay = 16'h0; mPending = 1'b0;
      lastIdx = -1; lastDiv = -1;
    end else begin
      div   = t % SD;
      idx   = (t / SD) % ND;
      bnd   = (t % FR) == FR - 1;
      e.seg = expSeg(mDisplay, idx);
      e.den = (div >= GD) ? 4'(1 << idx) : 4'h0;
      e.ack = bnd && mPending;
      if (bnd && mPending) begin
        mDisplay = mShadow;
        mPending = 1'b0;
      end
      if (l) begin
        mShadow  = b;
        mPending = 1'b1;
      end
      t++;
      lastIdx = idx;
      lastDiv = div;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("seg", 32'(seg), 32'(g.seg));
    check("digit_en", 32'(digit_en), 32'(g.den));
    check("load_ack", 32'(load_ack), 32'(g.ack));
    if (load_ack === 1'b1) ackSeen++;
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic idleTo(input int phase);
    for (int n = 0; n < 2*FR && (t % FR) != phase; n++) step(0, 0, 16'h0);
  endtask

  // Runs one whole frame and checks each digit mid-slot against the table.
  task automatic showFrame(input vec_t v);
    for (int n = 0; n < FR; n++) begin
      step(0, 0, 16'h0);
      if (lastDiv == 4) begin
        check($sformatf("tbl_%04h_d%0d", v.val, lastIdx), 32'(seg), 32'(v.exp[lastIdx]));
        check($sformatf("tbl_%04h_en%0d", v.val, lastIdx), 32'(digit_en), 32'(1 << lastIdx));
      end
    end
  endtask

  initial begin
    tbl[0] = '{val: 16'h1234, exp: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    tbl[1] = '{val: 16'hFA09, exp: {7'h00, 7'h00, 7'h3F, 7'h6F}};
    tbl[2] = '{val: 16'h8765, exp: {7'h7F, 7'h07, 7'h7D, 7'h6D}};
    tbl[3] = '{val: 16'h0040, exp: {LZ,    LZ,    7'h66, 7'h3F}};
    tbl[4] = '{val: 16'h0000, exp: {LZ,    LZ,    LZ,    7'h3F}};
    tbl[5] = '{val: 16'h9012, exp: {7'h6F, 7'h3F, 7'h06, 7'h5B}};
    tbl[6] = '{val: 16'h0007, exp: {LZ,    LZ,    LZ,    7'h07}};

    for (int n = 0; n < 3; n++) step(1, 0, 16'h0);
    check("rst_seg", 32'(seg), 32'h00);
    check("rst_digit_en", 32'(digit_en), 32'h0);
    check("rst_load_ack", 32'(load_ack), 32'h0);
    showFrame(tbl[4]);

    // Mid-frame loads (idx=1) across the vector table.
    for (int i = 0; i < 5; i++) begin
      idleTo(8);
      step(0, 1, tbl[i].val);
      ackSeen = 0;
      idleTo(0);
      check($sformatf("ack_count_%04h", tbl[i].val), 32'(ackSeen), 32'd1);
      showFrame(tbl[i]);
    end

    // Collision: latest value wins, then a load exactly on the boundary edge.
    idleTo(4);
    step(0, 1, 16'h5678);
    idleTo(12);
    step(0, 1, 16'h9012);
    ackSeen = 0;
    idleTo(FR - 1);
    step(0, 1, 16'h0007);
    check("collision_one_ack", 32'(ackSeen), 32'd1);
    ackSeen = 0;
    showFrame(tbl[5]);
    check("boundary_load_second_ack", 32'(ackSeen), 32'd1);
    ackSeen = 0;
    showFrame(tbl[6]);
    check("no_extra_ack", 32'(ackSeen), 32'd0);

    // Reset with a pending value at idx=2 drops it.
    idleTo(2);
    step(0, 1, 16'h4321);
    idleTo(16);
    step(1, 0, 16'h0);
    check("midrst_seg", 32'(seg), 32'h00);
    check("midrst_digit_en", 32'(digit_en), 32'h0);
    check("midrst_load_ack", 32'(load_ack), 32'h0);
    ackSeen = 0;
    showFrame(tbl[4]);
    showFrame(tbl[4]);
    check("midrst_no_ack", 32'(ackSeen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
